// File: rtl/i281_clock_controller.sv
// i281 CPU clock-enable sequencer: free-run divider, debounced single-step and latched halt.
// The CPU stays on CLK_IN and advances only on the one-cycle CPU_EN pulse.
module i281_clock_controller #(
   parameter int DIV_BITS      = 9,
   parameter int DEBOUNCE_BITS = 4
) (
   input  logic        CLK_IN,
   input  logic        RESET,
   input  logic        MODE_RUN,
   input  logic [1:0]  RATE_SEL,
   input  logic        STEP_BTN,
   input  logic        HALT_REQ,
   input  logic        CLEAR_HALT,
   output logic        CPU_EN,
   output logic [1:0]  STATE,
   output logic [15:0] CYCLE_COUNT
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_RUN       = 2'b01,
      ST_STEP_WAIT = 2'b10,
      ST_HALTED    = 2'b11
   } state_t;

   state_t                   state_q, state_d;
   logic [DIV_BITS-1:0]      div_q, div_d;
   logic [DIV_BITS-1:0]      tap_mask;
   logic                     cpu_en_q, cpu_en_d;
   logic [15:0]              cycle_count_q, cycle_count_d;
   logic                     sync1_q, sync1_d;
   logic                     sync2_q, sync2_d;
   logic                     db_level_q, db_level_d;
   logic                     db_prev_q, db_prev_d;
   logic                     step_evt_q, step_evt_d;
   logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;

   // Button conditioning: 2-FF synchronizer, stability counter, registered rising-edge event.
   always_comb begin
      sync1_d    = STEP_BTN;
      sync2_d    = sync1_q;
      db_level_d = db_level_q;
      db_cnt_d   = '0;
      if (sync2_q != db_level_q) begin
         if (db_cnt_q == '1) begin
            db_level_d = ~db_level_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      db_prev_d  = db_level_q;
      step_evt_d = db_level_q & ~db_prev_q;
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cpu_en_d = 1'b0;
      // tap+1 low bits set, i.e. DIV_BITS - 2*RATE_SEL ones
      tap_mask = {DIV_BITS{1'b1}} >> {RATE_SEL, 1'b0};
      case (state_q)
         ST_IDLE: begin
            if (HALT_REQ) begin
               state_d = ST_HALTED;
            end else if (MODE_RUN) begin
               state_d = ST_RUN;
               div_d   = '0;
            end else if (step_evt_q) begin
               cpu_en_d = 1'b1;
               state_d  = ST_STEP_WAIT;
            end
         end
         ST_RUN: begin
            if (HALT_REQ) begin
               state_d = ST_HALTED;
            end else if (!MODE_RUN) begin
               state_d = ST_IDLE;
            end else begin
               div_d    = div_q + 1'b1;
               cpu_en_d = &(div_q | ~tap_mask);
            end
         end
         ST_STEP_WAIT: begin
            if (HALT_REQ) begin
               state_d = ST_HALTED;
            end else if (!db_level_q) begin
               state_d = ST_IDLE;
            end
         end
         ST_HALTED: begin
            if (CLEAR_HALT) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      cycle_count_d = cycle_count_q + {15'd0, cpu_en_d};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   // NOTE: reset is synchronous and clears every flop, including the divider and debounce counters.
   always_ff @(posedge CLK_IN) begin
      if (RESET) begin
         state_q       <= ST_IDLE;
         div_q         <= '0;
         cpu_en_q      <= 1'b0;
         cycle_count_q <= '0;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         db_level_q    <= 1'b0;
         db_prev_q     <= 1'b0;
         step_evt_q    <= 1'b0;
         db_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         cpu_en_q      <= cpu_en_d;
         cycle_count_q <= cycle_count_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         db_level_q    <= db_level_d;
         db_prev_q     <= db_prev_d;
         step_evt_q    <= step_evt_d;
         db_cnt_q      <= db_cnt_d;
      end
   end

   assign CPU_EN      = cpu_en_q;
   assign STATE       = state_q;
   assign CYCLE_COUNT = cycle_count_q;

endmodule

// File: tb/tb_i281_clock_controller.sv
// Directed bench for i281_clock_controller: reset, run rates, bounced step, halt, restart, wrap.
module tb_i281_clock_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode_run;
   logic [1:0]  rate_sel;
   logic        step_btn;
   logic        halt_req;
   logic        clear_halt;
   logic        cpu_en;
   logic [1:0]  state;
   logic [15:0] cycle_count;

   int n_total = 0;
   int n_bad   = 0;
   int pulses;
   int misplaced;
   int p1;
   int p2;
   int pulse_at;
   int first;
   int glitch_len [4] = '{3, 2, 3, 2};

   always #5 clk = ~clk;

   i281_clock_controller dut (
      .CLK_IN      (clk),
      .RESET       (rst),
      .MODE_RUN    (mode_run),
      .RATE_SEL    (rate_sel),
      .STEP_BTN    (step_btn),
      .HALT_REQ    (halt_req),
      .CLEAR_HALT  (clear_halt),
      .CPU_EN      (cpu_en),
      .STATE       (state),
      .CYCLE_COUNT (cycle_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      mode_run   = 1'b0;
      step_btn   = 1'b0;
      halt_req   = 1'b0;
      clear_halt = 1'b0;
      rate_sel   = 2'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset values with run and button asserted
      rst = 1'b1; mode_run = 1'b1; step_btn = 1'b1;
      halt_req = 1'b0; clear_halt = 1'b0; rate_sel = 2'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_state", state, 0);
         check("rst_en", cpu_en, 0);
         check("rst_cnt", cycle_count, 0);
      end
      rst = 1'b0;
      tick();
      check("post_rst_en", cpu_en, 0);
      check("post_rst_cnt", cycle_count, 0);
      check("post_rst_state_run", state, 1);

      // Run rate 3 (period 8), then rate 0 (period 512) without clearing the divider
      do_reset();
      rate_sel = 2'd3; mode_run = 1'b1;
      tick();
      check("run_entry", state, 1);
      pulses = 0; misplaced = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (cpu_en) begin
            pulses++;
            if (i % 8 != 0) misplaced++;
         end
      end
      check("rate3_pulses", pulses, 12);
      check("rate3_misplaced", misplaced, 0);
      check("rate3_count", cycle_count, 12);
      rate_sel = 2'd0;
      p1 = 0; p2 = 0;
      for (int i = 101; i <= 1030; i++) begin
         tick();
         if (cpu_en) begin
            if (p1 == 0) p1 = i;
            else if (p2 == 0) p2 = i;
         end
      end
      check("rate0_first", p1, 512);
      check("rate0_second", p2, 1024);
      check("rate0_count", cycle_count, 14);

      // Single step with a bouncing button
      do_reset();
      tick(); tick();
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         step_btn = (k % 2 == 0);
         for (int j = 0; j < glitch_len[k]; j++) begin
            tick();
            if (cpu_en) pulses++;
         end
      end
      check("glitch_state", state, 0);
      step_btn = 1'b1;
      pulse_at = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (cpu_en) begin
            pulses++;
            pulse_at = i;
         end
         if (i == 20) check("step_wait_state", state, 2);
      end
      step_btn = 1'b0;
      for (int j = 0; j <= 30; j++) begin
         tick();
         if (cpu_en) pulses++;
         if (j == 17) check("release_still_wait", state, 2);
         if (j == 18) check("release_idle", state, 0);
      end
      check("step_pulses", pulses, 1);
      check("step_latency", pulse_at, 19);
      check("step_count", cycle_count, 1);

      // Halt at terminal count, inputs ignored while halted, clear
      do_reset();
      rate_sel = 2'd3; mode_run = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("halt_no_en", cpu_en, 0);
      check("halt_state", state, 3);
      pulses = 0;
      step_btn = 1'b1; mode_run = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (cpu_en) pulses++;
      end
      step_btn = 1'b0; mode_run = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (cpu_en) pulses++;
      end
      mode_run = 1'b0;
      tick();
      if (cpu_en) pulses++;
      check("halted_pulses", pulses, 0);
      check("halted_hold", state, 3);
      check("halted_count", cycle_count, 0);
      clear_halt = 1'b1;
      tick();
      check("clear_idle", state, 0);
      halt_req = 1'b1;
      tick();
      check("halt_beats_clear", state, 3);
      halt_req = 1'b0;
      tick();
      check("clear_again", state, 0);
      clear_halt = 1'b0;

      // Stop mid-run at divider 5, restart clears the divider
      do_reset();
      rate_sel = 2'd3; mode_run = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      mode_run = 1'b0;
      tick();
      check("stop_idle", state, 0);
      check("stop_no_en", cpu_en, 0);
      mode_run = 1'b1;
      tick();
      check("restart_run", state, 1);
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (cpu_en && first == 0) first = i;
      end
      check("restart_first", first, 8);

      // Counter wrap: preload near the top instead of issuing 65535 pulses
      do_reset();
      rate_sel = 2'd3; mode_run = 1'b1;
      tick();
      tick(); tick();
      force dut.cycle_count_q = 16'hFFFD;
      #1;
      release dut.cycle_count_q;
      for (int i = 3; i <= 24; i++) begin
         tick();
         if (i == 8) begin
            check("wrap_en8", cpu_en, 1);
            check("wrap_cnt8", cycle_count, 16'hFFFE);
         end
         if (i == 16) check("wrap_cnt16", cycle_count, 16'hFFFF);
         if (i == 23) begin
            check("wrap_en23", cpu_en, 0);
            check("wrap_cnt23", cycle_count, 16'hFFFF);
         end
         if (i == 24) begin
            check("wrap_en24", cpu_en, 1);
            check("wrap_cnt24", cycle_count, 16'h0000);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
